// File: rtl/config_pkg.sv
// -----------------------------------------------------------------------------
// config_pkg
// Shared definitions for the configuration sequencer:
//   - configuration section codes carried in config_addr[31:16]
//   - default idle address (section 16'hFFFF matches no section)
//   - sequencer FSM state encoding
//   - buffered request word {addr, data, last} (65 bits packed)
//   - rotl1() helper used by the optional load checksum
// -----------------------------------------------------------------------------
package config_pkg;

    localparam logic [15:0] CONFIG_SB  = 16'd7;
    localparam logic [15:0] CONFIG_CB0 = 16'd6;
    localparam logic [15:0] CONFIG_CB1 = 16'd5;
    localparam logic [15:0] CONFIG_CLB = 16'd4;

    localparam logic [31:0] IDLE_ADDR = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } config_req_t;

    function automatic logic [31:0] rotl1(input logic [31:0] value);
        return {value[30:0], value[31]};
    endfunction

endpackage

// File: rtl/config_sequencer_if.sv
// -----------------------------------------------------------------------------
// config_sequencer_if
// Bundles the host request stream and the shared tile configuration bus.
//   req_valid/req_ready/req_addr/req_data/req_last : host -> sequencer stream
//   config_addr/config_data                        : sequencer -> all tiles
//   busy/load_done/word_count                      : sequencer status
//   checksum (only with CONFIG_SEQ_CHECKSUM_EN)    : running load checksum
// Modports:
//   master : the host side (drives requests, observes bus and status)
//   slave  : the sequencer side
// -----------------------------------------------------------------------------
interface config_sequencer_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        req_last;

    logic [31:0] config_addr;
    logic [31:0] config_data;

    logic        busy;
    logic        load_done;
    logic [15:0] word_count;
`ifdef CONFIG_SEQ_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    modport master (
        output req_valid, req_addr, req_data, req_last,
        input  req_ready, config_addr, config_data, busy, load_done, word_count
`ifdef CONFIG_SEQ_CHECKSUM_EN
        , input checksum
`endif
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_last,
        output req_ready, config_addr, config_data, busy, load_done, word_count
`ifdef CONFIG_SEQ_CHECKSUM_EN
        , output checksum
`endif
    );

endinterface

// File: rtl/config_req_fifo.sv
// -----------------------------------------------------------------------------
// config_req_fifo
// Synchronous request buffer, FIFO_DEPTH entries of config_req_t (65 bits).
// Pointers carry one extra wrap bit: equal pointers mean empty, pointers that
// differ only in the wrap bit mean full.
// Ports:
//   clk, reset        clock, asynchronous active-low reset (empties the FIFO)
//   i_push, i_wdata   write strobe and word (ignored while full)
//   i_pop             read strobe (ignored while empty)
//   o_rdata           head word, valid while !o_empty
//   o_full, o_empty   occupancy flags decoded from the registered pointers
// -----------------------------------------------------------------------------
module config_req_fifo
    import config_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_push,
    input  config_req_t i_wdata,
    input  logic        i_pop,
    output config_req_t o_rdata,
    output logic        o_full,
    output logic        o_empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    config_req_t   r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // NOTE: storage is not reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/config_sequencer.sv
// -----------------------------------------------------------------------------
// config_sequencer
// Buffers (addr, data, last) writes from the host and plays them one at a time
// onto the shared tile configuration bus. Each word is held HOLD_CYCLES cycles
// and is always followed by idle bus cycles, so a tile's config_en drops
// between any two writes, even repeated writes to the same tile and section.
// Per word: IDLE (pop) -> ISSUE (HOLD_CYCLES) -> GAP (1), i.e. HOLD_CYCLES+2
// cycles. load_done pulses in the GAP that follows a last-flagged word.
//
// Parameters:
//   FIFO_DEPTH   request buffer entries (power of two, >= 2)
//   HOLD_CYCLES  bus hold time per word (1..15)
//   IDLE_ADDR    address driven whenever no write is on the bus
// Ports:
//   clk    clock, all state on the rising edge
//   reset  asynchronous active-low reset; aborts any write in flight
//   bus    config_sequencer_if.slave (request stream, config bus, status)
// Build option:
//   CONFIG_SEQ_CHECKSUM_EN  adds bus.checksum, a rotate-xor over the
//                           (addr ^ data) of every word in the current load.
// -----------------------------------------------------------------------------
module config_sequencer #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned HOLD_CYCLES = 1,
    parameter logic [31:0] IDLE_ADDR   = config_pkg::IDLE_ADDR
) (
    input logic              clk,
    input logic              reset,
    config_sequencer_if.slave bus
);

    import config_pkg::*;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    seq_state_t  r_state;
    seq_state_t  w_next_state;
    config_req_t r_cur;
    logic [3:0]  r_hold_cnt;
    logic [15:0] r_word_count;

    config_req_t w_req;
    config_req_t w_fifo_head;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic        w_push;
    logic        w_pop;
    logic        w_hold_done;
    logic [31:0] w_config_addr;
    logic [31:0] w_config_data;
    logic        w_load_done;
    logic        w_busy;

    // -------------------------------------------------------------------------
    // Request buffer
    // -------------------------------------------------------------------------
    assign w_req  = {bus.req_addr, bus.req_data, bus.req_last};
    assign w_push = bus.req_valid && !w_fifo_full;

    config_req_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata (w_req),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (!w_fifo_empty) w_next_state = ISSUE;
            ISSUE:   if (r_hold_cnt == 4'd0) w_next_state = GAP;
            GAP:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs. The bus is decoded from the state, so an asynchronous
    // reset forces the idle address in the same cycle it asserts.
    // -------------------------------------------------------------------------
    always_comb begin
        w_pop         = 1'b0;
        w_config_addr = IDLE_ADDR;
        w_config_data = '0;
        w_load_done   = 1'b0;
        unique case (r_state)
            IDLE:  w_pop = !w_fifo_empty;
            ISSUE: begin
                w_config_addr = r_cur.addr;
                w_config_data = r_cur.data;
            end
            GAP:   w_load_done = r_cur.last;
            default: ;
        endcase
    end

    assign w_busy      = !w_fifo_empty || (r_state != IDLE);
    assign w_hold_done = (r_state == ISSUE) && (r_hold_cnt == 4'd0);

    // -------------------------------------------------------------------------
    // Issued word and hold counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cur      <= '0;
            r_hold_cnt <= '0;
        end else if (w_pop) begin
            r_cur      <= w_fifo_head;
            r_hold_cnt <= HOLD_LOAD;
        end else if ((r_state == ISSUE) && (r_hold_cnt != 4'd0)) begin
            r_hold_cnt <= r_hold_cnt - 4'd1;
        end
    end

    // Counted on the ISSUE->GAP edge so the GAP cycle already shows the
    // word as issued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_word_count <= '0;
        end else if (w_hold_done && (r_word_count != 16'hFFFF)) begin
            r_word_count <= r_word_count + 16'd1;
        end
    end

`ifdef CONFIG_SEQ_CHECKSUM_EN
    // Updated on the ISSUE->GAP edge so the value seen alongside load_done
    // already includes the last word; cleared right after that GAP.
    logic [31:0] r_checksum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_checksum <= '0;
        end else if (w_hold_done) begin
            r_checksum <= rotl1(r_checksum) ^ r_cur.data ^ r_cur.addr;
        end else if (w_load_done) begin
            r_checksum <= '0;
        end
    end

    assign bus.checksum = r_checksum;
`endif

    // -------------------------------------------------------------------------
    // Interface outputs
    // -------------------------------------------------------------------------
    assign bus.req_ready   = !w_fifo_full;
    assign bus.config_addr = w_config_addr;
    assign bus.config_data = w_config_data;
    assign bus.busy        = w_busy;
    assign bus.load_done   = w_load_done;
    assign bus.word_count  = r_word_count;

endmodule

// File: tb/tb_config_sequencer.sv
// -----------------------------------------------------------------------------
// tb_config_sequencer
// Directed bench for config_sequencer. Two instances share clock and reset:
//   dut_h1 : FIFO_DEPTH=8, HOLD_CYCLES=1 (single-write timing)
//   dut_h3 : FIFO_DEPTH=8, HOLD_CYCLES=3 (burst, wrap, reset, tile, checksum)
// A bus monitor on dut_h3 turns the bus into a list of runs (addr, data,
// cycles held, idle cycles before), and a tile model with tile_id=3 decodes
// its four section enables from the bus. Everything is sampled on negedges.
// -----------------------------------------------------------------------------
module tb_config_sequencer;

    import config_pkg::*;

    logic clk;
    logic reset;

    config_sequencer_if if_h1 ();
    config_sequencer_if if_h3 ();

    config_sequencer #(
        .FIFO_DEPTH  (8),
        .HOLD_CYCLES (1),
        .IDLE_ADDR   (IDLE_ADDR)
    ) dut_h1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if_h1)
    );

    config_sequencer #(
        .FIFO_DEPTH  (8),
        .HOLD_CYCLES (3),
        .IDLE_ADDR   (IDLE_ADDR)
    ) dut_h3 (
        .clk   (clk),
        .reset (reset),
        .bus   (if_h3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Checking
    // -------------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    endtask

    // -------------------------------------------------------------------------
    // Bus monitor on dut_h3
    // -------------------------------------------------------------------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          len;
        int          gap;
    } bus_rec_t;

    bus_rec_t    mon_q[$];
    logic [31:0] run_addr;
    logic [31:0] run_data;
    int          run_len  = 0;
    int          run_gap  = 0;
    int          idle_len = 0;
    int          ld_count = 0;
    int          ld_bad   = 0;

    always @(negedge clk) begin
        if (if_h3.load_done) begin
            ld_count <= ld_count + 1;
            if (if_h3.config_addr != IDLE_ADDR) ld_bad <= ld_bad + 1;
        end
        if (if_h3.config_addr != IDLE_ADDR) begin
            if (run_len != 0 && (if_h3.config_addr != run_addr ||
                                 if_h3.config_data != run_data)) begin
                mon_q.push_back(bus_rec_t'{run_addr, run_data, run_len, run_gap});
                run_addr <= if_h3.config_addr;
                run_data <= if_h3.config_data;
                run_len  <= 1;
                run_gap  <= 0;
            end else if (run_len == 0) begin
                run_addr <= if_h3.config_addr;
                run_data <= if_h3.config_data;
                run_len  <= 1;
                run_gap  <= idle_len;
            end else begin
                run_len <= run_len + 1;
            end
            idle_len <= 0;
        end else begin
            if (run_len != 0) mon_q.push_back(bus_rec_t'{run_addr, run_data, run_len, run_gap});
            run_len  <= 0;
            idle_len <= idle_len + 1;
        end
    end

    // -------------------------------------------------------------------------
    // Tile model, tile_id=3; index 0..3 = CLB, CB1, CB0, SB
    // -------------------------------------------------------------------------
    logic        tile_clr = 1'b0;
    logic [3:0]  tile_hit;
    logic [3:0]  tile_en_prev;
    logic [31:0] tile_reg [4];
    int          tile_en_cycles [4];
    int          tile_en_rises [4];

    always_comb begin
        for (int s = 0; s < 4; s++)
            tile_hit[s] = (if_h3.config_addr == {CONFIG_CLB + 16'(s), 16'd3});
    end

    always @(negedge clk) begin
        if (tile_clr) begin
            tile_en_prev <= '0;
            for (int s = 0; s < 4; s++) begin
                tile_reg[s]       <= '0;
                tile_en_cycles[s] <= 0;
                tile_en_rises[s]  <= 0;
            end
        end else begin
            for (int s = 0; s < 4; s++) begin
                if (tile_hit[s]) begin
                    tile_reg[s]       <= if_h3.config_data;
                    tile_en_cycles[s] <= tile_en_cycles[s] + 1;
                    if (!tile_en_prev[s]) tile_en_rises[s] <= tile_en_rises[s] + 1;
                end
            end
            tile_en_prev <= tile_hit;
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers for dut_h3 (called and returning on a negedge)
    // -------------------------------------------------------------------------
    // Presents a word and leaves req_valid high so consecutive calls stream
    // back-to-back; returns just after the accepting edge.
    task automatic push3(input logic [31:0] a, input logic [31:0] d, input logic l);
        int waited;
        waited = 0;
        if_h3.req_addr  = a;
        if_h3.req_data  = d;
        if_h3.req_last  = l;
        if_h3.req_valid = 1'b1;
        while (!if_h3.req_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) check("push_timeout_ready", 32'(if_h3.req_ready), 1);
        @(negedge clk);
    endtask

    task automatic wait_idle3(input string tag, input int limit);
        int n;
        n = 0;
        while (if_h3.busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) check(tag, 32'(if_h3.busy), 0);
    endtask

    task automatic wait_addr3(input string tag, input logic [31:0] target, input int limit);
        int n;
        n = 0;
        while (if_h3.config_addr != target && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) check(tag, if_h3.config_addr, target);
    endtask

    // -------------------------------------------------------------------------
    // Main sequence
    // -------------------------------------------------------------------------
    int       base;
    int       ld0;
    bus_rec_t rec;

    initial begin
        reset           = 1'b0;
        if_h1.req_valid = 1'b0;
        if_h1.req_addr  = '0;
        if_h1.req_data  = '0;
        if_h1.req_last  = 1'b0;
        if_h3.req_valid = 1'b0;
        if_h3.req_addr  = '0;
        if_h3.req_data  = '0;
        if_h3.req_last  = 1'b0;
        repeat (3) @(negedge clk);

        // ---- Reset state -----------------------------------------------------
        check("rst_h1_addr",  if_h1.config_addr, IDLE_ADDR);
        check("rst_h1_data",  if_h1.config_data, 0);
        check("rst_h1_busy",  32'(if_h1.busy), 0);
        check("rst_h1_ready", 32'(if_h1.req_ready), 1);
        check("rst_h3_addr",  if_h3.config_addr, IDLE_ADDR);
        check("rst_h3_done",  32'(if_h3.load_done), 0);
        check("rst_h3_count", 32'(if_h3.word_count), 0);
`ifdef CONFIG_SEQ_CHECKSUM_EN
        check("rst_h3_checksum", if_h3.checksum, 0);
`endif
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // ---- Single write, HOLD_CYCLES=1 -------------------------------------
        // Accept at E0; popped at E1 so the word sits on the bus between E1
        // and E2 (tiles capture it at E2); GAP with load_done between E2/E3.
        if_h1.req_addr  = 32'h0006_0003;
        if_h1.req_data  = 32'd5;
        if_h1.req_last  = 1'b1;
        if_h1.req_valid = 1'b1;
        check("single_ready", 32'(if_h1.req_ready), 1);
        @(negedge clk);
        if_h1.req_valid = 1'b0;
        check("single_c1_addr", if_h1.config_addr, IDLE_ADDR);
        check("single_c1_busy", 32'(if_h1.busy), 1);
        @(negedge clk);
        check("single_c2_addr", if_h1.config_addr, 32'h0006_0003);
        check("single_c2_data", if_h1.config_data, 32'd5);
        check("single_c2_done", 32'(if_h1.load_done), 0);
        @(negedge clk);
        check("single_c3_addr",  if_h1.config_addr, IDLE_ADDR);
        check("single_c3_data",  if_h1.config_data, 0);
        check("single_c3_done",  32'(if_h1.load_done), 1);
        check("single_c3_count", 32'(if_h1.word_count), 1);
        @(negedge clk);
        check("single_c4_done", 32'(if_h1.load_done), 0);
        check("single_c4_busy", 32'(if_h1.busy), 0);

        // ---- Back-to-back burst, HOLD_CYCLES=3 -------------------------------
        // Accepts every edge E0..; pops at E1, E6, E11 (one per 5 cycles).
        // Occupancy reaches 8 at the 10th accept (E9), so ready drops there.
        base = mon_q.size();
        ld0  = ld_count;
        for (int k = 0; k < 10; k++)
            push3({16'h0006, 16'(k)}, 32'hA000_0000 | 32'(k), k == 9);
        check("burst_ready_full", 32'(if_h3.req_ready), 0);
        check("burst_busy", 32'(if_h3.busy), 1);
        if_h3.req_valid = 1'b0;
        wait_idle3("burst_drain_timeout", 200);
        repeat (2) @(negedge clk);
        check("burst_n_words", 32'(mon_q.size() - base), 10);
        for (int k = 0; k < 10 && base + k < mon_q.size(); k++) begin
            rec = mon_q[base + k];
            check($sformatf("burst_addr[%0d]", k), rec.addr, {16'h0006, 16'(k)});
            check($sformatf("burst_data[%0d]", k), rec.data, 32'hA000_0000 | 32'(k));
            check($sformatf("burst_hold[%0d]", k), 32'(rec.len), 3);
            if (k > 0) check($sformatf("burst_gap[%0d]", k), 32'(rec.gap), 2);
        end
        check("burst_load_done_n", 32'(ld_count - ld0), 1);
        check("burst_load_done_on_write", 32'(ld_bad), 0);
        check("burst_word_count", 32'(if_h3.word_count), 10);

        // ---- Full / pointer wrap: 20 words while draining --------------------
        base = mon_q.size();
        ld0  = ld_count;
        for (int k = 0; k < 20; k++)
            push3(32'(k), 32'h5000_0000 + 32'(k), k == 19);
        if_h3.req_valid = 1'b0;
        wait_idle3("wrap_drain_timeout", 300);
        repeat (2) @(negedge clk);
        check("wrap_n_words", 32'(mon_q.size() - base), 20);
        for (int k = 0; k < 20 && base + k < mon_q.size(); k++) begin
            rec = mon_q[base + k];
            check($sformatf("wrap_addr[%0d]", k), rec.addr, 32'(k));
            check($sformatf("wrap_data[%0d]", k), rec.data, 32'h5000_0000 + 32'(k));
        end
        check("wrap_load_done_n", 32'(ld_count - ld0), 1);
        check("wrap_word_count", 32'(if_h3.word_count), 30);

        // ---- Reset during ISSUE of word 2 of 4 -------------------------------
        for (int k = 0; k < 4; k++)
            push3({16'h0005, 16'h0010 + 16'(k)}, 32'hC000_0000 + 32'(k), k == 3);
        if_h3.req_valid = 1'b0;
        wait_addr3("rst_mid_wait_timeout", 32'h0005_0011, 50);
        reset = 1'b0;
        #1;
        check("rst_mid_addr",  if_h3.config_addr, IDLE_ADDR);
        check("rst_mid_data",  if_h3.config_data, 0);
        check("rst_mid_busy",  32'(if_h3.busy), 0);
        check("rst_mid_count", 32'(if_h3.word_count), 0);
        check("rst_mid_ready", 32'(if_h3.req_ready), 1);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        base = mon_q.size();
        repeat (20) @(negedge clk);
        check("rst_after_writes", 32'(mon_q.size() - base), 0);
        check("rst_after_busy",   32'(if_h3.busy), 0);
        check("rst_after_count",  32'(if_h3.word_count), 0);

`ifdef CONFIG_SEQ_CHECKSUM_EN
        // ---- Checksum over a two-word load -----------------------------------
        // rotl1(0) ^ 1 ^ 0004_0001 = 0004_0000
        // rotl1(0004_0000) ^ 2 ^ 0007_0001 = 0008_0000 ^ 0007_0003 = 000F_0003
        push3(32'h0004_0001, 32'd1, 1'b0);
        push3(32'h0007_0001, 32'd2, 1'b1);
        if_h3.req_valid = 1'b0;
        begin
            int n;
            n = 0;
            while (!if_h3.load_done && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) check("checksum_done_timeout", 32'(if_h3.load_done), 1);
        end
        check("checksum_on_done", if_h3.checksum, 32'h000F_0003);
        @(negedge clk);
        check("checksum_cleared", if_h3.checksum, 0);
        wait_idle3("checksum_drain_timeout", 50);
`endif

        // ---- Tile integration, tile_id=3 -------------------------------------
        tile_clr = 1'b1;
        repeat (2) @(negedge clk);
        tile_clr = 1'b0;
        @(negedge clk);
        push3({CONFIG_CB0, 16'd3}, 32'h0000_0011, 1'b0);
        push3({CONFIG_CB1, 16'd3}, 32'h0000_0022, 1'b0);
        push3({CONFIG_CLB, 16'd3}, 32'h0000_0033, 1'b0);
        push3({CONFIG_SB,  16'd3}, 32'h0000_0044, 1'b0);
        push3({CONFIG_CB0, 16'd4}, 32'h0000_0099, 1'b1);
        if_h3.req_valid = 1'b0;
        wait_idle3("tile_drain_timeout", 100);
        repeat (2) @(negedge clk);
        check("tile_clb_reg",    tile_reg[0], 32'h0000_0033);
        check("tile_cb1_reg",    tile_reg[1], 32'h0000_0022);
        check("tile_cb0_reg",    tile_reg[2], 32'h0000_0011);
        check("tile_sb_reg",     tile_reg[3], 32'h0000_0044);
        check("tile_clb_cycles", 32'(tile_en_cycles[0]), 3);
        check("tile_cb1_cycles", 32'(tile_en_cycles[1]), 3);
        check("tile_cb0_cycles", 32'(tile_en_cycles[2]), 3);
        check("tile_sb_cycles",  32'(tile_en_cycles[3]), 3);
        check("tile_clb_pulses", 32'(tile_en_rises[0]), 1);
        check("tile_cb1_pulses", 32'(tile_en_rises[1]), 1);
        check("tile_cb0_pulses", 32'(tile_en_rises[2]), 1);
        check("tile_sb_pulses",  32'(tile_en_rises[3]), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
